// File: rtl/trg_gen_if.sv
// Trigger-generator bus: burst control inputs and trigger/status outputs.
// master = controller side, slave = trg_gen side.
interface trg_gen_if #(
   parameter int PW = 16,
   parameter int WW = 8,
   parameter int NW = 16
);
   logic          Start;
   logic          Stop;
   logic [PW-1:0] Period;
   logic [WW-1:0] Width;
   logic [NW-1:0] Nburst;
   logic          Inhibit;
   logic          TReqOut;
   logic          Busy;
   logic          Done;
   logic [31:0]   Nsent;

   modport master (
      output Start, Stop, Period, Width, Nburst, Inhibit,
      input  TReqOut, Busy, Done, Nsent
   );

   modport slave (
      input  Start, Stop, Period, Width, Nburst, Inhibit,
      output TReqOut, Busy, Done, Nsent
   );
endinterface

// File: rtl/trg_gen.sv
// Programmable trigger-request burst generator with inhibit, stop and pulse count.
// Optional TRG_GEN_JITTER_EN adds an LFSR-driven 0..15 cycle extension to each low time.
module trg_gen #(
   parameter int PW = 16,
   parameter int WW = 8,
   parameter int NW = 16
) (
   input  logic    Clock,
   input  logic    Reset,
   trg_gen_if.slave trg_bus
);
   localparam logic [4:0] S_IDLE = 5'b00001;
   localparam logic [4:0] S_ARM  = 5'b00010;
   localparam logic [4:0] S_HIGH = 5'b00100;
   localparam logic [4:0] S_LOW  = 5'b01000;
   localparam logic [4:0] S_DONE = 5'b10000;
   localparam int CW = ((PW > WW) ? PW : WW) + 1;

   logic [4:0]    r_state;
   logic [PW-1:0] r_period;
   logic [WW-1:0] r_width;
   logic [NW-1:0] r_nburst;
   logic [NW-1:0] r_sent;
   logic [CW-1:0] r_cnt;
   logic          r_stop_pend;
   logic          r_treq;
   logic          r_busy;
   logic          r_done;
   logic [31:0]   r_nsent;

   logic [CW-1:0] w_we;
   logic [CW-1:0] w_le;
   logic          w_cnt_zero;
   logic          w_burst_done;
   logic          w_go_high;
   logic          w_go_low;
   logic          w_go_arm;
   logic          w_go_done;

`ifdef TRG_GEN_JITTER_EN
   logic [15:0] r_lfsr;
`endif

   always_comb begin
      w_we = (r_width == '0) ? CW'(1) : CW'(r_width);
      if (CW'(r_period) > w_we) w_le = CW'(r_period) - w_we;
      else                      w_le = CW'(1);
`ifdef TRG_GEN_JITTER_EN
      w_le = w_le + CW'(r_lfsr[3:0]);
`endif
      w_cnt_zero   = (r_cnt == '0);
      w_burst_done = (r_nburst != '0) && (r_sent == r_nburst);
   end

   // Burst-count completion outranks Stop and Inhibit at low-time expiry
   always_comb begin
      w_go_high = 1'b0;
      w_go_low  = 1'b0;
      w_go_arm  = 1'b0;
      w_go_done = 1'b0;
      case (r_state)
         S_ARM:
            if (trg_bus.Stop)          w_go_done = 1'b1;
            else if (!trg_bus.Inhibit) w_go_high = 1'b1;
         S_HIGH:
            if (w_cnt_zero) begin
               if (r_stop_pend || trg_bus.Stop) w_go_done = 1'b1;
               else                             w_go_low  = 1'b1;
            end
         S_LOW:
            if (w_cnt_zero) begin
               if (w_burst_done || trg_bus.Stop) w_go_done = 1'b1;
               else if (trg_bus.Inhibit)         w_go_arm  = 1'b1;
               else                              w_go_high = 1'b1;
            end else if (trg_bus.Stop) begin
               w_go_done = 1'b1;
            end
         default: ;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_period    <= '0;
         r_width     <= '0;
         r_nburst    <= '0;
         r_sent      <= '0;
         r_cnt       <= '0;
         r_stop_pend <= 1'b0;
         r_treq      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_nsent     <= '0;
`ifdef TRG_GEN_JITTER_EN
         r_lfsr      <= 16'hACE1;
`endif
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (trg_bus.Start) begin
               r_period    <= trg_bus.Period;
               r_width     <= trg_bus.Width;
               r_nburst    <= trg_bus.Nburst;
               r_sent      <= '0;
               r_stop_pend <= 1'b0;
               r_busy      <= 1'b1;
               r_state     <= S_ARM;
            end
         end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
         end

         if (r_state == S_HIGH && trg_bus.Stop) r_stop_pend <= 1'b1;

         if (w_go_high) begin
            r_state     <= S_HIGH;
            r_treq      <= 1'b1;
            r_cnt       <= w_we - CW'(1);
            r_nsent     <= r_nsent + 32'd1;
            r_sent      <= r_sent + NW'(1);
            r_stop_pend <= 1'b0;
`ifdef TRG_GEN_JITTER_EN
            r_lfsr      <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
`endif
         end else if (w_go_low) begin
            r_state <= S_LOW;
            r_treq  <= 1'b0;
            r_cnt   <= w_le - CW'(1);
         end else if (w_go_arm) begin
            r_state <= S_ARM;
         end else if (w_go_done) begin
            r_state <= S_DONE;
            r_treq  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
         end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   assign trg_bus.TReqOut = r_treq;
   assign trg_bus.Busy    = r_busy;
   assign trg_bus.Done    = r_done;
   assign trg_bus.Nsent   = r_nsent;
endmodule

// File: doc/trg_gen.md
Name: trg_gen

Overview:
- Programmable trigger-request transmitter; drives TReqOut into the trigger input of the energy-detector/tracker trigger monitors.
- Used for calibration, bench and self-test runs.
- Emits a burst of fixed-width pulses at a programmable rising-edge-to-rising-edge period, honours an external inhibit, and counts the pulses it sends.
- Every pulse is followed by at least one low cycle, so downstream edge-detecting counters see every trigger.

Parameters:
- PW, 16, width of Period input (cycles).
- WW, 8, width of Width input (cycles).
- NW, 16, width of Nburst input (pulse count).

Ports:
- Clock  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- Stop  input  1  abort request; sampled in any non-IDLE state.
- Period  input  PW  cycles from one rising edge to the next.
- Width  input  WW  pulse high time in cycles.
- Nburst  input  NW  number of pulses; 0 = continuous until Stop.
- Inhibit  input  1  downstream busy; defers the next rising edge.
- TReqOut  output  1  trigger request, registered.
- Busy  output  1  high from the cycle after Start until Done.
- Done  output  1  one-cycle pulse at burst end.
- Nsent  output  32  total pulses emitted since Reset.

Behaviour:
- Clocking and reset:
  - All outputs are registered.
  - Reset (synchronous, active-high) forces state IDLE and sets TReqOut=0, Busy=0, Done=0, Nsent=0, and all internal counters to 0.
  - Reset mid-pulse drops TReqOut on the next edge.
- Parameter latching:
  - Start in IDLE latches Period, Width and Nburst into internal registers.
  - Input changes during a burst are ignored.
- Derived timing values:
  - Effective width We = max(Width,1).
  - Effective low time Le = Period-We when Period>We, else 1.
  - Hence minimum period = We+1.
- States (one-hot):
  - IDLE:
    - Start=1 goes to ARM.
    - Busy=1 from the next cycle.
  - ARM:
    - Inhibit=1 stays in ARM.
    - Inhibit=0 goes to HIGH; TReqOut rises on entry to HIGH, so first rising edge = 2 cycles after Start when Inhibit=0.
  - HIGH:
    - TReqOut=1 for exactly We cycles.
    - Nsent increments by 1 in the first HIGH cycle; 32-bit wrap at 2^32-1 to 0.
    - The burst counter increments at the same time.
    - After We cycles, go to LOW.
  - LOW:
    - TReqOut=0 for Le cycles.
    - At expiry, go to DONE if Nburst!=0 and the pulses sent equal Nburst.
    - Otherwise, at expiry, go to ARM if Inhibit=1, or directly to HIGH if Inhibit=0.
    - Thus the period is exact when not inhibited.
  - DONE:
    - Done=1 and Busy=0 for one cycle, then IDLE.
- Stop:
  - Stop in ARM or LOW goes to DONE on the next edge.
  - Stop in HIGH is remembered; the pulse completes its full We cycles, then goes to DONE.
  - A pulse is never truncated.
  - Stop and Start in IDLE: Start wins; Stop is ignored in IDLE.
- Inhibit:
  - Inhibit never truncates a HIGH pulse.
  - Inhibit only delays rising edges.
- Start outside IDLE: ignored.
- Simultaneous events: the LOW expiry count check takes precedence over Inhibit, so a completed burst always ends without waiting.

Optional Feature:
- Macro: TRG_GEN_JITTER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on Reset) advances once per pulse, on HIGH entry.
  - Le is increased by the LFSR low 4 bits (0..15 cycles), giving a pseudo-random period for pile-up studies.
  - Width and counting are unchanged.
- Undefined:
  - No LFSR is present.
  - Period is exact as specified above.

Test Plan:
- Reset in mid-HIGH -> next edge TReqOut=0, Busy=0, Nsent=0, state IDLE.
- Start with Period=10, Width=3, Nburst=4, Inhibit=0 ->
  - first rise 2 cycles after Start;
  - 4 pulses, each 3 high, 7 low;
  - rising edges 10 cycles apart;
  - Done one cycle after the last LOW;
  - Nsent=4.
- Period=2, Width=5, Nburst=3 -> pulses 5 high, 1 low (period 6); Width=0 gives 1-cycle pulses.
- Nburst=0, Period=8, Width=2, Stop asserted in the 2nd cycle of pulse 5 -> pulse 5 is full 2 cycles, Done follows, Nsent=5.
- Period=6, Width=2, Nburst=3, Inhibit high for 20 cycles starting in LOW after pulse 1 -> TReqOut stays low, then rises 1 cycle after Inhibit falls; Nburst still completes at 3.
- Force Nsent to 32'hFFFFFFFF (via 2^32-1 preload hierarchical deposit), one pulse -> Nsent=0; with TRG_GEN_JITTER_EN, 16 pulses at Period=10, Width=2 -> every rise-to-rise interval lies in 10..25 and matches the LFSR reference model.
